// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester/response bundle for mult_arbiter.
// master = clients + consumer side, slave = arbiter side.
interface mult_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [2*WIDTH-1:0]    resp_x;
  logic [ID_W-1:0]       resp_id;
  logic                  busy;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_x,
    input  resp_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_x,
    output resp_id,
    output busy
  );

endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin share of one WIDTHxWIDTH multiplier.
// Define MULT_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module mult_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [ID_W-1:0]    r_id;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [ID_W-1:0]    w_winner;
  logic [2*WIDTH-1:0] w_prod;
  logic [NREQ-1:0]    w_grant;
  logic               w_any;
  logic               w_accept;

  assign w_any    = |bus.req_valid;
  assign w_accept = (r_state == S_IDLE) && w_any;

`ifdef MULT_ARB_FIXED_PRIO_EN

  always_comb begin
    w_winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_winner = ID_W'(i);
      end
    end
  end

`else

  logic [ID_W-1:0] r_last_grant;
  logic [ID_W-1:0] w_hi;
  logic [ID_W-1:0] w_lo;
  logic            w_hi_vld;

  // Requesters above last_grant beat those at or below it (wrap).
  always_comb begin
    w_hi     = '0;
    w_lo     = '0;
    w_hi_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (i > int'(r_last_grant)) begin
          w_hi     = ID_W'(i);
          w_hi_vld = 1'b1;
        end else begin
          w_lo = ID_W'(i);
        end
      end
    end
    w_winner = w_hi_vld ? w_hi : w_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= ID_W'(NREQ - 1);
    end else if (w_accept) begin
      r_last_grant <= w_winner;
    end
  end

`endif

  always_comb begin
    w_a     = '0;
    w_b     = '0;
    w_grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_a        = bus.req_a[i*WIDTH +: WIDTH];
        w_b        = bus.req_b[i*WIDTH +: WIDTH];
        w_grant[i] = w_accept;
      end
    end
  end

  assign w_prod = {{WIDTH{1'b0}}, r_op_a}
                * {{WIDTH{1'b0}}, r_op_b};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_id    <= '0;
      r_prod  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op_a <= w_a;
        r_op_b <= w_b;
        r_id   <= w_winner;
      end
      if (r_state == S_CALC) begin
        r_prod <= w_prod;
      end
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_x     = r_prod;
  assign bus.resp_id    = r_id;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
